// File: rtl/dmem_responder.sv
// Responder for the CPU data-memory port: valid/ready request and response channels,
// programmable latency, byte-lane word array. Optional `DMEM_MISALIGN_ERR_EN flags misaligned half/word accesses.
module dmem_responder #(
    parameter int               DATAW     = 32,
    parameter logic [DATAW-1:0] BASE_ADDR = 32'h01000000,
    parameter int               MEM_WORDS = 1024,
    parameter int               LATENCY   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [1:0]       req_size,
    input  logic [DATAW-1:0] req_addr,
    input  logic [DATAW-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DATAW-1:0] rsp_rdata,
    output logic             rsp_err
);

    localparam int               AW        = $clog2(MEM_WORDS);
    localparam logic [DATAW-1:0] MEM_BYTES = DATAW'(MEM_WORDS * 4);
    localparam logic [3:0]       LAT_INIT  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             rw_q;
    logic [1:0]       size_q;
    logic [DATAW-1:0] addr_q, wdata_q, rdata_q;
    logic             err_q;
    logic             capture, enter_resp;

    logic [DATAW-1:0] mem_q [MEM_WORDS];

    logic             eff_rw;
    logic [1:0]       eff_size;
    logic [DATAW-1:0] eff_addr, eff_wdata, offset;
    logic [1:0]       lane, lane_a;
    logic [AW-1:0]    widx;
    logic             mis_err, err;
    logic [3:0]       be;
    logic [DATAW-1:0] wr_data, rd_word, rd_shift, rd_val;

    // In IDLE the live request feeds the decode so that LATENCY=1 can respond on the accept edge.
    assign eff_rw    = (state_q == S_IDLE) ? req_rw    : rw_q;
    assign eff_size  = (state_q == S_IDLE) ? req_size  : size_q;
    assign eff_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign eff_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

    assign offset = eff_addr - BASE_ADDR;
    assign lane   = offset[1:0];
    assign widx   = offset[AW+1:2];

    always_comb begin
        lane_a  = lane;
        mis_err = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        mis_err = ((eff_size == 2'b01) && lane[0]) || ((eff_size == 2'b10) && (lane != 2'b00));
`else
        if (eff_size == 2'b01)      lane_a = {lane[1], 1'b0};
        else if (eff_size == 2'b10) lane_a = 2'b00;
`endif
    end

    assign err = (eff_size == 2'b11) || (offset >= MEM_BYTES) || mis_err;

    always_comb begin
        case (eff_size)
            2'b00:   be = 4'b0001 << lane_a;
            2'b01:   be = 4'b0011 << lane_a;
            default: be = 4'b1111;
        endcase
        wr_data  = eff_wdata << {lane_a, 3'b000};
        rd_word  = mem_q[widx];
        rd_shift = rd_word >> {lane_a, 3'b000};
        case (eff_size)
            2'b00:   rd_val = DATAW'(rd_shift[7:0]);
            2'b01:   rd_val = DATAW'(rd_shift[15:0]);
            default: rd_val = rd_shift;
        endcase
    end

    // NOTE: every output of a combinational block is given a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: if (req_valid) begin
                capture = 1'b1;
                cnt_d   = LAT_INIT;
                if (LATENCY == 1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                rw_q    <= req_rw;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                err_q   <= err;
                rdata_q <= (err || eff_rw) ? '0 : rd_val;
            end
        end
    end

    // NOTE: the array has no reset; contents survive reset and it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (enter_resp && eff_rw && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[widx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the CPU data-memory interface: accepts load/store requests over a valid/ready request channel and answers each on a valid/ready response channel after a programmable latency.
- Backed by a byte-lane word array.
- Sits between the pipeline's memory stage and storage; replaces the zero-latency data memory when multi-cycle memory timing is exercised.

Parameters:
- DATAW, 32, data and address width.
- BASE_ADDR, 32'h01000000, byte address of word 0.
- MEM_WORDS, 1024, depth of the word array.
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low; 0 forces reset immediately.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_rw  input  1  0 = read (load), 1 = write (store).
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_addr  input  DATAW  byte address.
- req_wdata  input  DATAW  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  DATAW  load data, right-aligned, zero-extended; 0 for writes and errors.
- rsp_err  output  1  request was illegal; no memory effect.

Behaviour:
- Reset values (reset low): state IDLE, latency counter 0, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, captured request registers 0. The memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid && req_ready, latch rw/size/addr/wdata and load counter=LATENCY-1.
  - If LATENCY=1, go directly to RESP.
  - Otherwise go to WAIT.
- WAIT: req_ready=0. Decrement counter each cycle; at counter==1, go to RESP on the next edge.
- Latency: acceptance edge at cycle N, so rsp_valid is first high in cycle N+LATENCY.
- Entry to RESP (the edge that asserts rsp_valid):
  - Compute the error flag.
  - A legal write commits to the array on this edge only.
  - A legal read samples the array on this edge into rsp_rdata.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On the handshake, return to IDLE. rsp_valid drops on that edge.
  - No back-to-back accept: the next request is accepted no earlier than the cycle after the handshake.
- Offset rules:
  - offset = req_addr - BASE_ADDR (unsigned, DATAW bits).
  - word index = offset[DATAW-1:2].
  - lane = offset[1:0].
- Error conditions, any of:
  - size==11;
  - offset >= MEM_WORDS*4 (this includes addresses below BASE_ADDR, which wrap to a large offset);
  - misalignment (see Optional Feature).
  - On error: no write, rsp_rdata=0, rsp_err=1.
- Writes:
  - Byte: wdata[7:0] written to lane.
  - Half: wdata[15:0] written to lanes lane and lane+1.
  - Word: all four lanes.
  - Untouched lanes keep their old value.
- Reads: the selected byte, half or word is shifted down to bit 0 and zero-extended. Sign extension remains the CPU's job.
- Ignored inputs: req_valid is ignored outside IDLE. req_* may change freely after acceptance.
- Reset mid-operation: a request still in WAIT is aborted with no array write, and no response is ever produced for it. A write already committed in RESP stays committed.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined: a half with lane[0]=1, or a word with lane!=00, is an error.
- Undefined: misaligned addresses are force-aligned and never flag an error.
  - Half: lane[0] is cleared.
  - Word: lane is cleared.

Test Plan:
- Word write/read, LATENCY=2: write 0xDEADBEEF to 0x01000010 (req accepted at cycle N), read it back.
  - Write: rsp_valid first high at N+2 with rsp_err=0, rsp_rdata=0.
  - Read: rsp_rdata=0xDEADBEEF.
- Byte merge: word 0x11223344 at 0x01000020, then byte write 0xAA to 0x01000022.
  - Word read returns 0x11AA3344.
  - Byte read of 0x01000023 returns 0x00000011.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises.
  - rsp_valid, rsp_rdata and rsp_err stay stable.
  - req_ready=0 throughout.
  - After the handshake, req_ready=1 on the next cycle.
- Errors:
  - Read at 0x00FFFFFC (below base): rsp_err=1, rdata=0.
  - Write at BASE_ADDR+MEM_WORDS*4: rsp_err=1, and a later read of word 0 is unchanged.
  - size=11: rsp_err=1.
- Misalign: word read at 0x01000012 after 0xCAFEF00D was written at 0x01000010.
  - With DMEM_MISALIGN_ERR_EN: rsp_err=1.
  - Without it: rsp_rdata=0xCAFEF00D, rsp_err=0.
- Async reset: pull reset low mid-WAIT of a write of 0x5A5A5A5A to 0x01000030, not aligned to clock.
  - Outputs reach their reset values immediately.
  - No response appears.
  - A read after reset release returns the old contents of 0x01000030.
